// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, bus widths and default timing for the SRAM controller.
package sram_ctrl_pkg;
    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned DEF_SETUP_CYC  = 1;
    localparam int unsigned DEF_STROBE_CYC = 2;
    localparam int unsigned DEF_HOLD_CYC   = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // The timer counts down to zero, so an N-cycle state loads N-1.
    function automatic logic [CNT_W-1:0] cyc_load(input int unsigned cyc);
        return CNT_W'(cyc - 1);
    endfunction
endpackage

// File: rtl/sram_timer.sv
// sram_timer: loadable down-counter whose terminal count ends each timed phase.
module sram_timer
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc_o = cnt_q == '0;
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-request asynchronous SRAM controller with programmable setup/strobe/hold timing.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              wr_done_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_oe_o,
    output logic              mem_we_o,
    inout  wire  [DATA_W-1:0] mem_data_io
);
    state_e            state_q, state_d;
    logic              accept, we_q, we_d;
    logic              timer_load, timer_tc, strobe_last;
    logic [CNT_W-1:0]  timer_val;
    logic              mem_oe_q, mem_we_q, drive_q, rsp_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    assign accept = req_valid_i && state_q == ST_IDLE;
    assign we_d   = accept ? req_we_i : we_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = req_valid_i ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_d = timer_tc ? ST_STROBE : ST_SETUP;
            ST_STROBE: state_d = timer_tc ? ST_HOLD : ST_STROBE;
            default:   state_d = timer_tc ? ST_IDLE : ST_HOLD;
        endcase
    end

    // One shared timer, reloaded with the length of whichever phase is entered.
    assign timer_load  = state_d != state_q;
    assign timer_val   = state_d == ST_SETUP  ? cyc_load(SETUP_CYC)  :
                         state_d == ST_STROBE ? cyc_load(STROBE_CYC) : cyc_load(HOLD_CYC);
    assign strobe_last = state_q == ST_STROBE && timer_tc;

    sram_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tc_o       (timer_tc)
    );

    // Strobes and bus enable are decoded from the next state so they leave flops cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_oe_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= accept ? req_addr_i : addr_q;
            wdata_q     <= accept ? req_wdata_i : wdata_q;
            rdata_q     <= (strobe_last && !we_q) ? mem_data_io : rdata_q;
            mem_oe_q    <= !(state_d == ST_STROBE && !we_d);
            mem_we_q    <= !(state_d == ST_STROBE && we_d);
            drive_q     <= state_d != ST_IDLE && we_d;
            rsp_valid_q <= strobe_last && !we_q;
        end
    end

    assign req_ready_o = state_q == ST_IDLE;
    assign busy_o      = state_q != ST_IDLE;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign wr_done_o   = state_q == ST_HOLD && timer_tc && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_oe_o    = mem_oe_q;
    assign mem_we_o    = mem_we_q;
    assign mem_data_io = drive_q ? wdata_q : {DATA_W{1'bz}};

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) mem_oe_q || mem_we_q);
    a_no_contend:  assert property (@(posedge clk) disable iff (!rst_n) mem_oe_q || !drive_q);
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed and random transactions on two timing variants against a behavioural SRAM and memory model.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int B_S = 3, B_P = 1, B_H = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        req_valid, req_we;
    logic [15:0] req_addr, req_wdata;

    logic        a_ready, a_rv, a_wd, a_busy, a_oe, a_we;
    logic [15:0] a_rdata, a_addr;
    wire  [15:0] a_bus;
    logic        b_ready, b_rv, b_wd, b_busy, b_oe, b_we;
    logic [15:0] b_rdata, b_addr;
    wire  [15:0] b_bus;

    logic [15:0] sram [0:65535];
    assign a_bus = a_oe ? 16'hzzzz : sram[a_addr];
    assign b_bus = b_oe ? 16'hzzzz : sram[b_addr];
    always @(posedge clk) begin
        if (!a_we) sram[a_addr] <= a_bus;
        if (!b_we) sram[b_addr] <= b_bus;
    end

    sram_ctrl dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid && !sel), .req_ready_o(a_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(a_rv), .rsp_rdata_o(a_rdata), .wr_done_o(a_wd), .busy_o(a_busy),
        .mem_addr_o(a_addr), .mem_oe_o(a_oe), .mem_we_o(a_we), .mem_data_io(a_bus)
    );

    sram_ctrl #(.SETUP_CYC(B_S), .STROBE_CYC(B_P), .HOLD_CYC(B_H)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid && sel), .req_ready_o(b_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(b_rv), .rsp_rdata_o(b_rdata), .wr_done_o(b_wd), .busy_o(b_busy),
        .mem_addr_o(b_addr), .mem_oe_o(b_oe), .mem_we_o(b_we), .mem_data_io(b_bus)
    );

    logic        o_ready, o_rv, o_wd, o_busy, o_oe, o_we;
    logic [15:0] o_rdata, o_addr, o_bus;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_rv    = sel ? b_rv    : a_rv;
    assign o_wd    = sel ? b_wd    : a_wd;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_oe    = sel ? b_oe    : a_oe;
    assign o_we    = sel ? b_we    : a_we;
    assign o_rdata = sel ? b_rdata : a_rdata;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_bus   = sel ? b_bus   : a_bus;

    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, last_strobe = 0;
    int          S, P, H;
    logic        prev_keep;
    logic [15:0] last_rd [2];
    logic [15:0] ref_mem [logic [15:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("a_oe_we_overlap", 32'(a_oe | a_we), 1);
        chk("b_oe_we_overlap", 32'(b_oe | b_we), 1);
    endtask

    task automatic use_dut(input logic s);
        sel = s;
        S = s ? B_S : DEF_SETUP_CYC;
        P = s ? B_P : DEF_STROBE_CYC;
        H = s ? B_H : DEF_HOLD_CYC;
        prev_keep = 1'b0;
    endtask

    // Expected timeline relative to acceptance: strobe in k = S+1..S+P, response at S+P+1, done at S+P+H, ready at 1+S+P+H.
    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wd, input logic keep);
        int          t = 1 + S + P + H;
        int          guard = 0;
        bit          strobe;
        logic [15:0] exp_rd = 16'h0;
        while (!o_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("ready_before_req", 32'(o_ready), 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        if (we) ref_mem[addr] = wd;
        else    exp_rd = ref_mem.exists(addr) ? ref_mem[addr] : sram[addr];
        tick();
        req_valid = keep;
        req_we    = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        for (int k = 1; k <= t; k++) begin
            strobe = k >= 1 + S && k <= S + P;
            chk("busy", 32'(o_busy), 32'(k < t));
            chk("ready", 32'(o_ready), 32'(k == t));
            chk("mem_addr", 32'(o_addr), 32'(addr));
            chk("mem_we_n", 32'(o_we), 32'(!(we && strobe)));
            chk("mem_oe_n", 32'(o_oe), 32'(!(!we && strobe)));
            chk("rsp_valid", 32'(o_rv), 32'(!we && k == 1 + S + P));
            chk("wr_done", 32'(o_wd), 32'(we && k == t - 1));
            if (we && k < t) chk("mem_data_wr", 32'(o_bus), 32'(wd));
            if (!we && strobe) chk("mem_data_rd", 32'(o_bus), 32'(exp_rd));
            if (!we && k >= 1 + S + P) chk("rsp_rdata", 32'(o_rdata), 32'(exp_rd));
            if (we) chk("rdata_hold", 32'(o_rdata), 32'(last_rd[sel]));
            if (k == 1 + S) begin
                if (prev_keep) chk("strobe_spacing", 32'(cyc - last_strobe), 32'(t));
                last_strobe = cyc;
            end
            if (k < t) tick();
        end
        if (!we) last_rd[sel] = exp_rd;
        prev_keep = keep;
    endtask

    initial begin
        logic        kp;
        logic [15:0] ra;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        use_dut(1'b0);
        tick();
        tick();
        chk("rst_a_oe", 32'(a_oe), 1);
        chk("rst_a_we", 32'(a_we), 1);
        chk("rst_a_addr", 32'(a_addr), 0);
        chk("rst_a_rv", 32'(a_rv), 0);
        chk("rst_a_wd", 32'(a_wd), 0);
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_a_rdata", 32'(a_rdata), 0);
        chk("rst_b_oe", 32'(b_oe), 1);
        chk("rst_b_busy", 32'(b_busy), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_a_ready", 32'(a_ready), 1);
        chk("rst_b_ready", 32'(b_ready), 1);

        txn(1'b1, 16'h0010, 16'hA5A5, 1'b0);
        txn(1'b1, 16'h0003, 16'h1234, 1'b0);
        txn(1'b0, 16'h0003, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) txn(1'b1, 16'h0100 + 16'(i), 16'($urandom), i < 3);

        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0003;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_oe", 32'(a_oe), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_oe", 32'(a_oe), 1);
        chk("async_rst_busy", 32'(a_busy), 0);
        chk("async_rst_rdata", 32'(a_rdata), 0);
        chk("async_rst_addr", 32'(a_addr), 0);
        tick();
        rst_n = 1'b1;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        prev_keep  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_rv", 32'(a_rv), 0);
            chk("post_rst_oe", 32'(a_oe), 1);
            chk("post_rst_busy", 32'(a_busy), 0);
        end
        txn(1'b0, 16'h0003, 16'h0000, 1'b0);

        for (int i = 0; i < 8; i++) txn(1'b1, 16'h0040 + 16'(i), 16'($urandom), 1'b1);
        for (int i = 0; i < 40; i++) begin
            kp = (i < 39) && 1'($urandom);
            ra = 16'h0040 + 16'($urandom_range(0, 7));
            txn(1'($urandom), ra, 16'($urandom), kp);
            if (!kp && 1'($urandom)) begin
                tick();
                prev_keep = 1'b0;
            end
        end

        req_valid = 1'b0;
        tick();
        use_dut(1'b1);
        txn(1'b1, 16'hFFFF, 16'hBEEF, 1'b1);
        txn(1'b0, 16'hFFFF, 16'h0000, 1'b1);
        txn(1'b1, 16'h0000, 16'h5A5A, 1'b1);
        for (int i = 0; i < 6; i++) txn(1'($urandom), 16'hFFFF - 16'($urandom_range(0, 1)) * 16'hFFFF, 16'($urandom), i < 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
